data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Shares the single-ported `DataMemory` between two requesters: port 0 is the pipeline MEM stage and port 1 is the test-loader/DMA port. The block arbitrates round-robin and drives `DataMemory`'s `memRead_i`, `memWrite_i`, `ALUOut_i` and `WriteData_i` for a fixed, parameterised access latency. It registers read data and returns a one-cycle acknowledge. It also produces the pipeline stall while a port-0 access is outstanding.

## Interface
- `LATENCY`, default 2: number of cycles the memory strobes are held per access; legal range 1–15.
- `DEPTH`, default 32: number of memory words; addresses `>= DEPTH` are rejected.
- `clk_i` input 1: clock, all state on rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `req_i` input 2: request per port; held high with stable `we`/`addr`/`wdata` until that port's `ack_o`.
- `we_i` input 2: per port, 1 = write, 0 = read.
- `addr0_i`, `addr1_i` input 32: word address per port.
- `wdata0_i`, `wdata1_i` input 32: write data per port.
- `ack_o` output 2: one-cycle completion pulse per port.
- `err_o` output 2: one-cycle pulse with `ack_o` when the address was out of range.
- `rdata_o` output 32: registered read data; valid in the `ack_o` cycle and held until the next read completes.
- `stall_o` output 1: `req_i[0] & ~ack_o[0]`; goes to the hazard/stall logic.
- `memRead_o`, `memWrite_o` output 1: strobes to `DataMemory`.
- `memAddr_o`, `memWdata_o` output 32: address and data to `DataMemory`.
- `memRdata_i` input 32: `ReadData_o` from `DataMemory`.

## Operation
- States are IDLE, ACCESS and RESP.
- IDLE:
  - Evaluates `req_i` each cycle.
  - One request: grant it. Both requests: grant the port opposite `lastGrant`.
  - On grant: latch port index, `we`, `addr` and `wdata`. Update `lastGrant` to the granted port. Load `cnt = LATENCY-1`.
  - In-range address: go to ACCESS. Out-of-range address: go directly to RESP with the error flag set; no strobes are issued.
- ACCESS:
  - `memAddr_o` and `memWdata_o` carry the latched values.
  - `memWrite_o = we`; `memRead_o = ~we`.
  - `cnt` decrements each cycle. At `cnt == 0`, a read captures `memRdata_i` into the `rdata` register, then the state moves to RESP.
- RESP:
  - `ack_o[granted] = 1` for exactly one cycle; `err_o[granted]` is set if flagged.
  - Strobes are low.
  - Next state is IDLE. The requester deasserts `req_i` in the cycle after `ack_o`.
- Requests arriving during ACCESS or RESP wait; they are evaluated in IDLE.
- Writes do not change `rdata_o`.
- Out-of-range check is `addr >= DEPTH`. It compares all 32 bits, so there is no wrap-around.
- Outside ACCESS, `memAddr_o` and `memWdata_o` are 0 and both strobes are 0.

## Timing
- Reset values:
  - State IDLE, `cnt` 0, `lastGrant` 1 (port 0 wins the first contention).
  - `ack_o` 0, `err_o` 0, `rdata_o` 0.
  - Strobes and memory address/data outputs 0.
- Reset assertion forces all strobes low immediately (asynchronous). Any in-flight access is aborted with no `ack_o`.
- Request to `ack_o` for an in-range access:
  - Request sampled in IDLE at edge N.
  - ACCESS occupies cycles N+1 through N+LATENCY.
  - `ack_o` is high in cycle N+LATENCY+1.
- Out-of-range request: `ack_o`/`err_o` are high in cycle N+1.
- Throughput: one access per LATENCY+2 cycles, because IDLE is mandatory between accesses.
- Strobes are registered-state decodes with no combinational path from `req_i` to `mem*_o`.
- `stall_o` is combinational from `req_i` and `ack_o`.

## Structure
- Shared package `dmem_pkg`:
  - State enum with values IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Port index constants `PORT_CPU`=0 and `PORT_DMA`=1.
  - Default `DEPTH`.
- No sub-module is needed.
- The round-robin chooser is a small function in the same file.
- The testbench instantiates `DataMemory` as the memory model.

## Test plan
- Single read: after preloading mem[5]=32'hDEADBEEF, a port 0 read of addr 5 with LATENCY=2 -> `memRead_o` high for 2 cycles, `ack_o[0]` in cycle 3, `rdata_o`=DEADBEEF, `stall_o` high for cycles 0–2.
- Write then read: port 1 writes 32'h12345678 to addr 31, then port 0 reads addr 31 -> `ack_o[1]`, then `ack_o[0]` with `rdata_o`=12345678.
- Contention: both ports request in the same cycle twice in a row, from reset -> grant order is 0, 1, 0, 1; no ack is ever lost.
- Out-of-range: a port 0 read of addr 32 -> `ack_o[0]` and `err_o[0]` in cycle 1; strobes never assert; `rdata_o` is unchanged.
- Reset mid-ACCESS: a write in flight with LATENCY=4, `rst_i` pulsed in its 2nd ACCESS cycle -> `memWrite_o` drops in the same cycle, there is no `ack_o`, and state is IDLE after release.
- LATENCY=1: back-to-back port 0 reads of addr 0 and addr 1 -> acks 3 cycles apart.

Source files
------------

// File: rtl/dmem_pkg.sv
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared types and constants for the data-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester port indices
    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

    // Default number of data-memory words
    localparam int DEFAULT_DEPTH = 32;

endpackage : dmem_pkg

`default_nettype wire

// File: rtl/dmem_data_memory.sv
// ============================================================================
//  Module      : DataMemory
//  Description : Single-ported word memory; synchronous write, asynchronous
//                read. Accesses outside DEPTH are ignored and read as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module DataMemory #(
    parameter int DEPTH = 32
) (
    input  logic        clk_i,
    input  logic        memRead_i,
    input  logic        memWrite_i,
    input  logic [31:0] ALUOut_i,
    input  logic [31:0] WriteData_i,
    output logic [31:0] ReadData_o
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] w_idx;
    logic          w_in_range;

    assign w_idx      = ALUOut_i[AW-1:0];
    assign w_in_range = (ALUOut_i < DEPTH_LIM);

    // Store write data on the clock edge while the write strobe is high
    always_ff @(posedge clk_i) begin
        if (memWrite_i && w_in_range) begin
            mem_q[w_idx] <= WriteData_i;
        end
    end

    assign ReadData_o = (memRead_i && w_in_range) ? mem_q[w_idx] : 32'd0;

endmodule : DataMemory

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ============================================================================
//  Module      : data_mem_arbiter
//  Description : Round-robin arbiter sharing DataMemory between the pipeline
//                MEM stage (port 0) and the loader/DMA port (port 1). Holds
//                the memory strobes for LATENCY cycles, registers read data,
//                returns a one-cycle ack/err and raises the port-0 stall.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_arbiter
    import dmem_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = DEFAULT_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    output logic [1:0]  ack_o,
    output logic [1:0]  err_o,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        memRead_o,
    output logic        memWrite_o,
    output logic [31:0] memAddr_o,
    output logic [31:0] memWdata_o,
    input  logic [31:0] memRdata_i
);

    localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH);

    // Both requesting: alternate against the last winner; otherwise the lone requester
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        w_pick;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;

    assign w_pick  = rr_pick(req_i, last_grant_q);
    assign w_addr  = w_pick ? addr1_i  : addr0_i;
    assign w_wdata = w_pick ? wdata1_i : wdata0_i;

    // State and datapath registers; reset aborts any in-flight access
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // Next-state: grant in IDLE, count down the access, single RESP cycle
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    port_d       = w_pick;
                    last_grant_d = w_pick;
                    we_d         = we_i[w_pick];
                    addr_d       = w_addr;
                    wdata_d      = w_wdata;
                    cnt_d        = CNT_LOAD;
                    // Full 32-bit compare: large addresses never alias into range
                    if (w_addr >= DEPTH_LIM) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        rdata_d = memRdata_i;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only, so no req_i path reaches mem*_o
    always_comb begin
        memRead_o  = 1'b0;
        memWrite_o = 1'b0;
        memAddr_o  = 32'd0;
        memWdata_o = 32'd0;
        ack_o      = 2'b00;
        err_o      = 2'b00;
        case (state_q)
            ACCESS: begin
                memRead_o  = ~we_q;
                memWrite_o = we_q;
                memAddr_o  = addr_q;
                memWdata_o = wdata_q;
            end
            RESP: begin
                ack_o[port_q] = 1'b1;
                err_o[port_q] = err_q;
            end
            default: begin
            end
        endcase
    end

    assign rdata_o = rdata_q;
    assign stall_o = req_i[PORT_CPU] & ~ack_o[PORT_CPU];

endmodule : data_mem_arbiter

`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
// ============================================================================
//  Module      : tb_data_mem_arbiter
//  Description : Directed self-checking bench; three arbiter instances with
//                LATENCY 2, 4 and 1, each driving its own DataMemory.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic [1:0]  req   [3];
    logic [1:0]  we    [3];
    logic [31:0] a0    [3];
    logic [31:0] a1    [3];
    logic [31:0] d0    [3];
    logic [31:0] d1    [3];
    logic [1:0]  ack   [3];
    logic [1:0]  err   [3];
    logic [31:0] rdata [3];
    logic        stall [3];
    logic        mrd   [3];
    logic        mwr   [3];
    logic [31:0] maddr [3];
    logic [31:0] mwd   [3];
    logic [31:0] mrdat [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 4 : 1);
        data_mem_arbiter #(.LATENCY(LAT), .DEPTH(32)) u_dut (
            .clk_i      (clk),
            .rst_i      (rst),
            .req_i      (req[g]),
            .we_i       (we[g]),
            .addr0_i    (a0[g]),
            .addr1_i    (a1[g]),
            .wdata0_i   (d0[g]),
            .wdata1_i   (d1[g]),
            .ack_o      (ack[g]),
            .err_o      (err[g]),
            .rdata_o    (rdata[g]),
            .stall_o    (stall[g]),
            .memRead_o  (mrd[g]),
            .memWrite_o (mwr[g]),
            .memAddr_o  (maddr[g]),
            .memWdata_o (mwd[g]),
            .memRdata_i (mrdat[g])
        );
        DataMemory #(.DEPTH(32)) u_mem (
            .clk_i       (clk),
            .memRead_i   (mrd[g]),
            .memWrite_i  (mwr[g]),
            .ALUOut_i    (maddr[g]),
            .WriteData_i (mwd[g]),
            .ReadData_o  (mrdat[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access on instance i, port p; cycle 0 is the IDLE cycle where req rises
    task automatic run(input int i, input int p, input logic w, input logic [31:0] a,
                       input logic [31:0] d, output int ack_cyc, output int rd_n,
                       output int wr_n, output int st_n, output logic e,
                       output logic [31:0] seen_addr);
        ack_cyc = -1; rd_n = 0; wr_n = 0; st_n = 0; e = 1'b0; seen_addr = 32'd0;
        @(negedge clk); #1;
        we[i][p] = w;
        if (p == 0) begin a0[i] = a; d0[i] = d; end
        else        begin a1[i] = a; d1[i] = d; end
        req[i][p] = 1'b1;
        #1;
        for (int k = 0; k < 40; k++) begin
            if (mrd[i]) rd_n++;
            if (mwr[i]) wr_n++;
            if (mrd[i] | mwr[i]) seen_addr = maddr[i];
            if (stall[i]) st_n++;
            if (ack[i][p]) begin
                ack_cyc   = k;
                e         = err[i][p];
                req[i][p] = 1'b0;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    // Both ports request together on instance i; records grant order, rdata and ack cycle
    task automatic contend(input int i, input logic w0, input logic [31:0] ad0, input logic [31:0] dd0,
                           input logic w1, input logic [31:0] ad1, input logic [31:0] dd1,
                           output int ord0, output int ord1, output logic [31:0] r0,
                           output logic [31:0] r1, output int c0, output int c1);
        int n;
        n = 0; ord0 = -1; ord1 = -1; r0 = 32'd0; r1 = 32'd0; c0 = -1; c1 = -1;
        @(negedge clk); #1;
        we[i] = {w1, w0};
        a0[i] = ad0; d0[i] = dd0;
        a1[i] = ad1; d1[i] = dd1;
        req[i] = 2'b11;
        #1;
        for (int k = 0; k < 60; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (ack[i][p] && req[i][p]) begin
                    if (n == 0) begin ord0 = p; r0 = rdata[i]; c0 = k; end
                    else        begin ord1 = p; r1 = rdata[i]; c1 = k; end
                    n++;
                    req[i][p] = 1'b0;
                end
            end
            if (n >= 2) break;
            @(negedge clk); #1;
        end
    endtask

    initial begin
        int          ac, rn, wn, sn, o0, o1, c0, c1, nack, t0, t1, n;
        logic        e;
        logic [31:0] sa, r0, r1;

        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req[i] = 2'b00; we[i] = 2'b00;
            a0[i] = 32'd0; a1[i] = 32'd0; d0[i] = 32'd0; d1[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;

        // Reset state
        check("rst_ack",   32'(ack[0]),   32'd0);
        check("rst_err",   32'(err[0]),   32'd0);
        check("rst_rdata", rdata[0],      32'd0);
        check("rst_rd",    32'(mrd[0]),   32'd0);
        check("rst_wr",    32'(mwr[0]),   32'd0);
        check("rst_maddr", maddr[0],      32'd0);
        check("rst_mwd",   mwd[0],        32'd0);
        check("rst_stall", 32'(stall[0]), 32'd0);

        // Contention from reset, twice: order 0,1,0,1
        contend(0, 1'b1, 32'd2, 32'hAAAA0002, 1'b1, 32'd3, 32'hBBBB0003, o0, o1, r0, r1, c0, c1);
        check("cont1_first",  32'(o0), 32'd0);
        check("cont1_second", 32'(o1), 32'd1);
        check("cont1_ack0_cyc", 32'(c0), 32'd3);
        check("cont1_ack1_cyc", 32'(c1), 32'd7);
        contend(0, 1'b0, 32'd3, 32'd0, 1'b0, 32'd2, 32'd0, o0, o1, r0, r1, c0, c1);
        check("cont2_first",  32'(o0), 32'd0);
        check("cont2_second", 32'(o1), 32'd1);
        check("cont2_rdata0", r0, 32'hBBBB0003);
        check("cont2_rdata1", r1, 32'hAAAA0002);

        // Preload mem[5] through port 1, then single port-0 read
        run(0, 1, 1'b1, 32'd5, 32'hDEADBEEF, ac, rn, wn, sn, e, sa);
        check("pre5_ack_cyc", 32'(ac), 32'd3);
        check("pre5_stall",   32'(sn), 32'd0);
        run(0, 0, 1'b0, 32'd5, 32'd0, ac, rn, wn, sn, e, sa);
        check("rd5_ack_cyc", 32'(ac), 32'd3);
        check("rd5_rd_cyc",  32'(rn), 32'd2);
        check("rd5_wr_cyc",  32'(wn), 32'd0);
        check("rd5_stall",   32'(sn), 32'd3);
        check("rd5_err",     32'(e),  32'd0);
        check("rd5_addr",    sa,      32'd5);
        check("rd5_rdata",   rdata[0], 32'hDEADBEEF);

        // Port 1 write to addr 31, then port 0 read back
        run(0, 1, 1'b1, 32'd31, 32'h12345678, ac, rn, wn, sn, e, sa);
        check("wr31_ack_cyc", 32'(ac), 32'd3);
        check("wr31_wr_cyc",  32'(wn), 32'd2);
        check("wr31_rdata_kept", rdata[0], 32'hDEADBEEF);
        run(0, 0, 1'b0, 32'd31, 32'd0, ac, rn, wn, sn, e, sa);
        check("rd31_ack_cyc", 32'(ac), 32'd3);
        check("rd31_rdata",   rdata[0], 32'h12345678);

        // Out-of-range: addr 32 and a large address that would alias if truncated
        run(0, 0, 1'b0, 32'd32, 32'd0, ac, rn, wn, sn, e, sa);
        check("oor32_ack_cyc", 32'(ac), 32'd1);
        check("oor32_err",     32'(e),  32'd1);
        check("oor32_strobes", 32'(rn + wn), 32'd0);
        check("oor32_rdata",   rdata[0], 32'h12345678);
        run(0, 1, 1'b1, 32'h8000_0005, 32'h0BADF00D, ac, rn, wn, sn, e, sa);
        check("oorbig_ack_cyc", 32'(ac), 32'd1);
        check("oorbig_err",     32'(e),  32'd1);
        check("oorbig_strobes", 32'(rn + wn), 32'd0);
        run(0, 0, 1'b0, 32'd5, 32'd0, ac, rn, wn, sn, e, sa);
        check("noalias_rdata", rdata[0], 32'hDEADBEEF);

        // LATENCY=1: preload, then back-to-back port-0 reads of addr 0 and 1
        run(2, 1, 1'b1, 32'd0, 32'h00001111, ac, rn, wn, sn, e, sa);
        check("l1_pre0_ack_cyc", 32'(ac), 32'd2);
        check("l1_pre0_wr_cyc",  32'(wn), 32'd1);
        run(2, 1, 1'b1, 32'd1, 32'h22220000, ac, rn, wn, sn, e, sa);
        check("l1_pre1_ack_cyc", 32'(ac), 32'd2);
        @(negedge clk); #1;
        we[2] = 2'b00; a0[2] = 32'd0; req[2][0] = 1'b1;
        #1;
        n = 0; t0 = -1; t1 = -1; r0 = 32'd0; r1 = 32'd0;
        for (int k = 0; k < 30; k++) begin
            if (ack[2][0]) begin
                if (n == 0) begin t0 = k; r0 = rdata[2]; a0[2] = 32'd1; end
                else        begin t1 = k; r1 = rdata[2]; req[2][0] = 1'b0; end
                n++;
                if (n >= 2) break;
            end
            @(negedge clk); #1;
        end
        check("l1_first_ack_cyc", 32'(t0), 32'd2);
        check("l1_ack_spacing",   32'(t1 - t0), 32'd3);
        check("l1_rdata0",        r0, 32'h00001111);
        check("l1_rdata1",        r1, 32'h22220000);

        // LATENCY=4: reset in the 2nd ACCESS cycle of a write
        @(negedge clk); #1;
        we[1] = 2'b01; a0[1] = 32'd7; d0[1] = 32'h77777777; req[1][0] = 1'b1;
        @(negedge clk); #1;
        check("rstmid_wr_acc1", 32'(mwr[1]), 32'd1);
        @(negedge clk); #1;
        check("rstmid_wr_acc2", 32'(mwr[1]), 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid_wr_drop",   32'(mwr[1]),   32'd0);
        check("rstmid_maddr_clr", maddr[1],      32'd0);
        req[1][0] = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        nack = 0;
        for (int k = 0; k < 8; k++) begin
            if (ack[1] != 2'b00) nack++;
            if (mwr[1] | mrd[1]) nack++;
            @(negedge clk); #1;
        end
        check("rstmid_no_ack",  32'(nack), 32'd0);
        check("rstmid_idle",    32'(g_dut[1].u_dut.state_q), 32'd0);

        // LATENCY=4 normal write/read after the aborted access
        run(1, 0, 1'b1, 32'd9, 32'hCAFEF00D, ac, rn, wn, sn, e, sa);
        check("l4_wr_ack_cyc", 32'(ac), 32'd5);
        check("l4_wr_cyc",     32'(wn), 32'd4);
        run(1, 1, 1'b0, 32'd9, 32'd0, ac, rn, wn, sn, e, sa);
        check("l4_rd_ack_cyc", 32'(ac), 32'd5);
        check("l4_rd_cyc",     32'(rn), 32'd4);
        check("l4_rd_stall",   32'(sn), 32'd0);
        check("l4_rdata",      rdata[1], 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_data_mem_arbiter

`default_nettype wire
